// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state and grant encodings shared by the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_DM   = 2'b10;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: DM-first priority with a saturating starvation counter that forces IF through.
module mem_arb_prio #(
  parameter int MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic gnt_i,
  output logic sel_if_o
);
  localparam logic [3:0] MAX = 4'(MAX_STARVE);
  logic [3:0] cnt_q, cnt_d;
  assign sel_if_o = if_req_i & (~dm_req_i | (cnt_q == MAX));
  // Only DM wins taken while IF waits count toward starvation.
  always_comb
    cnt_d = !gnt_i ? cnt_q : sel_if_o ? 4'd0 : (if_req_i && cnt_q != MAX) ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= 4'd0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access, one transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_done,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_done,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic [1:0]        o_grant,
  output logic              o_stall_if,
  output logic              o_stall_mem
);
  state_e              state_q;
  logic                mem_req_q, mem_we_q, if_done_q, dm_done_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic [1:0]          grant_q;
  logic                gnt, sel_if;
  assign gnt = (state_q == IDLE) && (i_if_req || i_dm_req);
  mem_arb_prio #(.MAX_STARVE(MAX_STARVE)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_req_i (i_if_req),
    .dm_req_i (i_dm_req),
    .gnt_i    (gnt),
    .sel_if_o (sel_if)
  );
  // Every grant returns through IDLE so a requester can drop req after its done pulse.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      grant_q     <= GNT_NONE;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt) begin
          state_q     <= sel_if ? BUSY_IF : BUSY_DM;
          mem_req_q   <= 1'b1;
          mem_we_q    <= sel_if ? 1'b0 : i_dm_we;
          mem_addr_q  <= sel_if ? i_if_addr : i_dm_addr;
          mem_wdata_q <= sel_if ? '0 : i_dm_wdata;
          grant_q     <= sel_if ? GNT_IF : GNT_DM;
        end
        default: if (i_mem_ready) begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          grant_q   <= GNT_NONE;
          if (state_q == BUSY_IF) begin
            if_done_q  <= 1'b1;
            if_rdata_q <= i_mem_rdata;
          end else begin
            dm_done_q <= 1'b1;
            if (!mem_we_q) dm_rdata_q <= i_mem_rdata;
          end
        end
      endcase
    end
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_if_done   = if_done_q;
  assign o_dm_done   = dm_done_q;
  assign o_grant     = grant_q;
  assign o_stall_if  = i_if_req & ~if_done_q;
  assign o_stall_mem = i_dm_req & ~dm_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, corner sequences and random traffic against a transaction model.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_done, dm_done, mem_req, mem_we, stall_if, stall_mem;
  logic [1:0] grant;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_STARVE(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_done(if_done),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_rdata(dm_rdata), .o_dm_done(dm_done),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
    .o_grant(grant), .o_stall_if(stall_if), .o_stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  bit m_busy;
  int m_own, m_cnt;
  logic m_req, m_we, m_ifd, m_dmd;
  logic [15:0] m_addr, m_wdata, m_ifrd, m_dmrd;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_own = 0; m_cnt = 0;
    m_req = 0; m_we = 0; m_ifd = 0; m_dmd = 0;
    m_addr = '0; m_wdata = '0; m_ifrd = '0; m_dmrd = '0;
  endfunction

  function automatic void model_edge();
    bit pick;
    m_ifd = 0; m_dmd = 0;
    if (!rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (if_req || dm_req) begin
        pick = if_req && (!dm_req || m_cnt == MAXS);
        if (pick) m_cnt = 0;
        else if (if_req) m_cnt = (m_cnt < MAXS) ? m_cnt + 1 : MAXS;
        m_busy = 1; m_own = pick ? 1 : 2; m_req = 1;
        m_we = pick ? 1'b0 : dm_we;
        m_addr = pick ? if_addr : dm_addr;
        m_wdata = pick ? 16'h0 : dm_wdata;
      end
    end else if (mem_ready) begin
      if (m_own == 1) begin m_ifd = 1; m_ifrd = mem_rdata; end
      else begin m_dmd = 1; if (!m_we) m_dmrd = mem_rdata; end
      m_busy = 0; m_req = 0; m_own = 0;
    end
  endfunction

  function automatic void check_all();
    chk("mem_req", mem_req, m_req);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("grant", grant, m_own);
    chk("if_done", if_done, m_ifd);
    chk("dm_done", dm_done, m_dmd);
    chk("if_rdata", if_rdata, m_ifrd);
    chk("dm_rdata", dm_rdata, m_dmrd);
    chk("stall_if", stall_if, if_req & ~m_ifd);
    chk("stall_mem", stall_mem, dm_req & ~m_dmd);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #3 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_gnt", grant, 0);
    chk("rst_done", {if_done, dm_done}, 0);
    check_all();
  endtask

  typedef struct {
    logic ifr, dmr, we, rdy;
    logic [15:0] ia, da, wd, rd;
    logic e_req, e_we;
    logic [15:0] e_addr, e_wd;
    logic [1:0] e_gnt;
    logic e_ifd, e_dmd;
    logic [15:0] e_ifrd, e_dmrd;
  } vec_t;

  vec_t tbl [11];
  int exp_g [10];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, prev, pulses, first;
    tbl[0]  = '{1,0,0,0, 16'h0040,16'h0000,16'h0000,16'h0000, 1,0,16'h0040,16'h0000,2'd1,0,0,16'h0000,16'h0000};
    tbl[1]  = '{1,0,0,1, 16'h0040,16'h0000,16'h0000,16'hD105, 0,0,16'h0000,16'h0000,2'd0,1,0,16'hD105,16'h0000};
    tbl[2]  = '{0,0,0,0, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,16'h0000,16'h0000,2'd0,0,0,16'hD105,16'h0000};
    tbl[3]  = '{0,1,1,0, 16'h0000,16'h0100,16'hBEEF,16'h0000, 1,1,16'h0100,16'hBEEF,2'd2,0,0,16'hD105,16'h0000};
    tbl[4]  = '{0,1,1,0, 16'h0000,16'h0200,16'h1234,16'h0000, 1,1,16'h0100,16'hBEEF,2'd2,0,0,16'hD105,16'h0000};
    tbl[5]  = '{0,1,1,0, 16'h0000,16'h0300,16'h4321,16'h0000, 1,1,16'h0100,16'hBEEF,2'd2,0,0,16'hD105,16'h0000};
    tbl[6]  = '{0,1,1,1, 16'h0000,16'h0100,16'hBEEF,16'h5555, 0,0,16'h0000,16'h0000,2'd0,0,1,16'hD105,16'h0000};
    tbl[7]  = '{0,0,0,1, 16'h0000,16'h0000,16'h0000,16'h7777, 0,0,16'h0000,16'h0000,2'd0,0,0,16'hD105,16'h0000};
    tbl[8]  = '{0,1,0,0, 16'h0000,16'h0300,16'h0000,16'h0000, 1,0,16'h0300,16'h0000,2'd2,0,0,16'hD105,16'h0000};
    tbl[9]  = '{0,1,0,1, 16'h0000,16'h0300,16'h0000,16'h0A5A, 0,0,16'h0000,16'h0000,2'd0,0,1,16'hD105,16'h0A5A};
    tbl[10] = '{0,0,0,0, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,16'h0000,16'h0000,2'd0,0,0,16'hD105,16'h0A5A};
    exp_g = '{2,2,2,2,1,2,2,2,2,1};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if_req = tbl[i].ifr; dm_req = tbl[i].dmr; dm_we = tbl[i].we; mem_ready = tbl[i].rdy;
      if_addr = tbl[i].ia; dm_addr = tbl[i].da; dm_wdata = tbl[i].wd; mem_rdata = tbl[i].rd;
      step();
      chk($sformatf("tbl%0d_req", i), mem_req, tbl[i].e_req);
      chk($sformatf("tbl%0d_gnt", i), grant, tbl[i].e_gnt);
      chk($sformatf("tbl%0d_ifd", i), if_done, tbl[i].e_ifd);
      chk($sformatf("tbl%0d_dmd", i), dm_done, tbl[i].e_dmd);
      chk($sformatf("tbl%0d_ifrd", i), if_rdata, tbl[i].e_ifrd);
      chk($sformatf("tbl%0d_dmrd", i), dm_rdata, tbl[i].e_dmrd);
      if (tbl[i].e_req) begin
        chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].e_we);
        chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_wd", i), mem_wdata, tbl[i].e_wd);
      end
    end

    if_req = 1; if_addr = 16'h0080; dm_req = 1; dm_we = 0; dm_addr = 16'h0400; mem_ready = 1;
    n = 0; prev = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      mem_rdata = 16'($urandom);
      step();
      if (grant != 2'd0 && prev == 0) begin
        chk($sformatf("contend_gnt%0d", n), grant, exp_g[n]);
        n++;
      end
      prev = int'(grant);
    end
    chk("contend_count", n, 10);
    if_req = 0; dm_req = 0;
    step(); step();

    dm_req = 1; dm_we = 0; dm_addr = 16'h0500; mem_ready = 0;
    step();
    chk("drop_gnt_dm", grant, 2);
    dm_req = 0; if_req = 1; if_addr = 16'h0600;
    step(); step();
    mem_ready = 1; mem_rdata = 16'h1111;
    pulses = 0; first = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      pulses += int'(dm_done);
      if (grant != 2'd0 && first == 0) first = int'(grant);
    end
    chk("drop_done_pulses", pulses, 1);
    chk("drop_dm_rdata", dm_rdata, 16'h1111);
    chk("drop_next_gnt", first, 1);
    if_req = 0;
    step(); step();

    if_req = 1; if_addr = 16'h0700; mem_ready = 0;
    step();
    chk("rstmid_busy", grant, 1);
    step();
    async_reset();
    if_req = 0;
    step();
    #2 rst = 1'b1;
    if_req = 1; if_addr = 16'h0044;
    step();
    chk("post_rst_gnt", grant, 1);
    chk("post_rst_addr", mem_addr, 16'h0044);
    mem_ready = 1; mem_rdata = 16'hCAFE;
    step();
    chk("post_rst_done", if_done, 1);
    chk("post_rst_rdata", if_rdata, 16'hCAFE);
    if_req = 0; mem_ready = 0;
    step();

    for (int i = 0; i < 1500; i++) begin
      if (if_req && if_done) if_req = ($urandom_range(0, 3) == 0);
      else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 30) == 0) if_req = 0;
      if (dm_req && dm_done) dm_req = ($urandom_range(0, 1) == 0);
      else if (!dm_req) dm_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 30) == 0) dm_req = 0;
      if_addr = 16'($urandom); dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
      dm_we = ($urandom_range(0, 1) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        #2 rst = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
